// File: rtl/lcd_pwm_bar_display.sv
// lcd_pwm_bar_display: parallel RGB panel timing generator drawing NUM_CH duty bars or test patterns.
// DUTY/MODE are shadowed once per frame so the picture never tears.
module lcd_pwm_bar_display #(
    parameter int          CLK_DIV  = 2,
    parameter int          H_SYNC   = 30,
    parameter int          H_BP     = 16,
    parameter int          H_ACTIVE = 800,
    parameter int          H_FP     = 210,
    parameter int          V_SYNC   = 13,
    parameter int          V_BP     = 10,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 22,
    parameter int          NUM_CH   = 4,
    parameter logic [23:0] BAR_RGB  = 24'h00FF00,
    parameter logic [23:0] BG_RGB   = 24'h000040
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [8*NUM_CH-1:0] DUTY,
    input  logic [1:0]          MODE,
    output logic                NCLK,
    output logic                GREST,
    output logic                HD,
    output logic                VD,
    output logic                DEN,
    output logic [7:0]          R,
    output logic [7:0]          G,
    output logic [7:0]          B,
    output logic                FRAME_START
);
    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = $clog2(CLK_DIV);
    localparam int BAR_H = V_ACTIVE / NUM_CH;

    logic [DW-1:0] div;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [7:0]    duty_sh [NUM_CH];
    logic [1:0]    mode_sh;
    logic          tick, origin, hd_n, vd_n, den_n;
    logic [7:0]    duty_sel;
    logic [2:0]    ci;
    logic [23:0]   pix, rgb_n;
    int            x, y;

    assign tick   = div == DW'(CLK_DIV - 1);
    assign origin = h == '0 && v == '0;
    assign NCLK   = div >= DW'(CLK_DIV / 2);

    // Decode the pre-increment position; results land on the pins at the tick.
    always_comb begin
        x        = int'(h) - (H_SYNC + H_BP);
        y        = int'(v) - (V_SYNC + V_BP);
        hd_n     = int'(h) >= H_SYNC;
        vd_n     = int'(v) >= V_SYNC;
        den_n    = x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE;
        duty_sel = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (y >= k * BAR_H && y < (k + 1) * BAR_H) duty_sel = duty_sh[k];
        ci       = 3'((x * 8) / H_ACTIVE);
        pix      = mode_sh == 2'd0 ? (x * 100 < int'(duty_sel) * H_ACTIVE ? BAR_RGB : BG_RGB) :
                   mode_sh == 2'd1 ? {{8{~ci[1]}}, {8{~ci[2]}}, {8{~ci[0]}}} :
                   mode_sh == 2'd2 ? 24'hFFFFFF : 24'h000000;
        rgb_n    = den_n ? pix : 24'h000000;
    end

    always_ff @(posedge CLK) begin
        GREST <= ~RST;
        if (RST) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            HD          <= 1'b1;
            VD          <= 1'b1;
            DEN         <= 1'b0;
            {R, G, B}   <= '0;
            FRAME_START <= 1'b0;
            mode_sh     <= '0;
            for (int k = 0; k < NUM_CH; k++) duty_sh[k] <= '0;
        end else begin
            div         <= tick ? '0 : div + DW'(1);
            FRAME_START <= tick && origin;
            if (tick) begin
                h         <= h == HW'(H_TOT - 1) ? '0 : h + HW'(1);
                if (h == HW'(H_TOT - 1)) v <= v == VW'(V_TOT - 1) ? '0 : v + VW'(1);
                HD        <= hd_n;
                VD        <= vd_n;
                DEN       <= den_n;
                {R, G, B} <= rgb_n;
                // Frame-boundary capture, duty clamped to 100 %.
                if (origin) begin
                    mode_sh <= MODE;
                    for (int k = 0; k < NUM_CH; k++)
                        duty_sh[k] <= DUTY[8*k +: 8] > 8'd100 ? 8'd100 : DUTY[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_pwm_bar_display.sv
// tb_lcd_pwm_bar_display: randomized frame-level checks of the LCD bar display against a pixel model.
module tb_lcd_pwm_bar_display;
    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;
    localparam logic [23:0] BAR = 24'h00FF00;
    localparam logic [23:0] BG  = 24'h000040;
    localparam logic [23:0] CB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  MODE = 2'd0;
    logic [15:0] DUTY = '0;
    logic [23:0] DUTY3 = '0;
    logic        NCLK, GREST, HD, VD, DEN, FRAME_START;
    logic [7:0]  R, G, B;
    logic        nclk3, grest3, hd3, vd3, den3, fs3;
    logic [7:0]  r3, g3, b3;
    int          checks = 0;
    int          passes = 0;

    lcd_pwm_bar_display #(
        .CLK_DIV(2), .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1), .NUM_CH(2)
    ) dut (
        .CLK(CLK), .RST(RST), .DUTY(DUTY), .MODE(MODE), .NCLK(NCLK), .GREST(GREST),
        .HD(HD), .VD(VD), .DEN(DEN), .R(R), .G(G), .B(B), .FRAME_START(FRAME_START)
    );

    lcd_pwm_bar_display #(
        .CLK_DIV(2), .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1), .NUM_CH(3)
    ) dut3 (
        .CLK(CLK), .RST(RST), .DUTY(DUTY3), .MODE(MODE), .NCLK(nclk3), .GREST(grest3),
        .HD(hd3), .VD(vd3), .DEN(den3), .R(r3), .G(g3), .B(b3), .FRAME_START(fs3)
    );

    always #5 CLK = ~CLK;

    // Pixel n of a frame (row-major from the sync corner) -> {HD, VD, DEN, RGB}.
    function automatic logic [26:0] model(int n, int nch, int mode, int d0, int d1, int d2);
        int h, v, x, y, k, dk, nb;
        logic den;
        logic [23:0] rgb;
        h   = n % HT;
        v   = n / HT;
        x   = h - 4;
        y   = v - 2;
        den = x >= 0 && x < 8 && y >= 0 && y < 4;
        rgb = 24'h000000;
        if (den) begin
            if (mode == 1) rgb = CB[x];
            else if (mode == 2) rgb = 24'hFFFFFF;
            else if (mode == 0) begin
                k   = y / (4 / nch);
                dk  = k == 0 ? d0 : k == 1 ? d1 : k == 2 ? d2 : 0;
                dk  = dk > 100 ? 100 : dk;
                nb  = (dk * 8 + 99) / 100;
                rgb = (k < nch && x < nb) ? BAR : BG;
            end
        end
        return {h >= 2, v >= 1, den, rgb};
    endfunction

    task automatic wait_frame;
        int i;
        i = 0;
        do begin
            @(negedge CLK);
            i++;
        end while (!FRAME_START && i < 400);
        checks++;
        if (!FRAME_START) $display("FAIL frame_sync: FRAME_START=%b after %0d cycles, need 1", FRAME_START, i);
        else passes++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLK);
        checks++;
        if ({HD, VD, DEN, GREST, NCLK, FRAME_START, R, G, B} !== {6'b110000, 24'h0})
            $display("FAIL reset_state: got %h need %h", {HD, VD, DEN, GREST, NCLK, FRAME_START, R, G, B}, {6'b110000, 24'h0});
        else passes++;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({GREST, FRAME_START} !== 2'b10) $display("FAIL grest_release: got %b need 10", {GREST, FRAME_START});
        else passes++;
        @(negedge CLK);
        checks++;
        if ({FRAME_START, HD, VD} !== 3'b100) $display("FAIL first_tick: got %b need 100", {FRAME_START, HD, VD});
        else passes++;
    endtask

    task automatic test_timing;
        int cnt, pos;
        cnt = 0;
        pos = -1;
        wait_frame;
        checks++;
        if (NCLK !== 1'b0) $display("FAIL nclk_low: got %b need 0", NCLK);
        else passes++;
        for (int i = 1; i <= 4 * FT; i++) begin
            @(negedge CLK);
            if (i == 1) begin
                checks++;
                if (NCLK !== 1'b1) $display("FAIL nclk_high: got %b need 1", NCLK);
                else passes++;
            end
            if (FRAME_START) begin
                cnt++;
                if (pos < 0) pos = i;
            end
        end
        checks++;
        if (cnt != 2 || pos != 2 * FT) $display("FAIL frame_period: got %0d pulses first at %0d, need 2 at %0d", cnt, pos, 2 * FT);
        else passes++;
    endtask

    task automatic test_bars;
        logic [26:0] e;
        MODE = 2'd0;
        DUTY = {8'd100, 8'd50};
        wait_frame;
        for (int n = 0; n < FT; n++) begin
            if (n > 0) repeat (2) @(negedge CLK);
            e = model(n, 2, 0, 50, 100, 0);
            checks++;
            if ({FRAME_START, HD, VD, DEN, R, G, B} !== {n == 0, e})
                $display("FAIL bars n=%0d: got %h need %h", n, {FRAME_START, HD, VD, DEN, R, G, B}, {n == 0, e});
            else passes++;
        end
    endtask

    task automatic test_clamp_midframe;
        logic [26:0] e;
        DUTY = {8'd200, 8'd0};
        wait_frame;
        for (int n = 0; n < FT; n++) begin
            if (n > 0) repeat (2) @(negedge CLK);
            if (n == 30) DUTY = {8'd30, 8'd75};
            e = model(n, 2, 0, 0, 200, 0);
            checks++;
            if ({FRAME_START, HD, VD, DEN, R, G, B} !== {n == 0, e})
                $display("FAIL clamp_hold n=%0d: got %h need %h", n, {FRAME_START, HD, VD, DEN, R, G, B}, {n == 0, e});
            else passes++;
        end
        wait_frame;
        for (int n = 0; n < FT; n++) begin
            if (n > 0) repeat (2) @(negedge CLK);
            e = model(n, 2, 0, 75, 30, 0);
            checks++;
            if ({HD, VD, DEN, R, G, B} !== e)
                $display("FAIL new_duty n=%0d: got %h need %h", n, {HD, VD, DEN, R, G, B}, e);
            else passes++;
        end
    endtask

    task automatic test_colour_modes;
        logic [26:0] e;
        for (int m = 1; m <= 3; m++) begin
            MODE = 2'(m);
            wait_frame;
            for (int n = 0; n < FT; n++) begin
                if (n > 0) repeat (2) @(negedge CLK);
                e = model(n, 2, m, 0, 0, 0);
                checks++;
                if ({HD, VD, DEN, R, G, B} !== e)
                    $display("FAIL mode%0d n=%0d: got %h need %h", m, n, {HD, VD, DEN, R, G, B}, e);
                else passes++;
            end
        end
    endtask

    task automatic test_num_ch3;
        logic [26:0] e;
        int d0, d1, d2;
        MODE = 2'd0;
        for (int f = 0; f < 3; f++) begin
            d0 = $urandom_range(255, 0);
            d1 = $urandom_range(120, 0);
            d2 = f == 0 ? 100 : $urandom_range(255, 0);
            DUTY3 = {8'(d2), 8'(d1), 8'(d0)};
            wait_frame;
            for (int n = 0; n < FT; n++) begin
                if (n > 0) repeat (2) @(negedge CLK);
                e = model(n, 3, 0, d0, d1, d2);
                checks++;
                if ({fs3, hd3, vd3, den3, r3, g3, b3} !== {n == 0, e})
                    $display("FAIL ch3 n=%0d: got %h need %h", n, {fs3, hd3, vd3, den3, r3, g3, b3}, {n == 0, e});
                else passes++;
            end
        end
    endtask

    task automatic test_random;
        logic [26:0] e;
        int m, d0, d1;
        for (int f = 0; f < 5; f++) begin
            m = $urandom_range(3, 0);
            if (f < 2) m = 0;
            d0 = $urandom_range(255, 0);
            d1 = $urandom_range(110, 0);
            MODE = 2'(m);
            DUTY = {8'(d1), 8'(d0)};
            wait_frame;
            for (int n = 0; n < FT; n++) begin
                if (n > 0) repeat (2) @(negedge CLK);
                e = model(n, 2, m, d0, d1, 0);
                checks++;
                if ({FRAME_START, HD, VD, DEN, R, G, B} !== {n == 0, e})
                    $display("FAIL random f=%0d n=%0d: got %h need %h", f, n, {FRAME_START, HD, VD, DEN, R, G, B}, {n == 0, e});
                else passes++;
            end
        end
    endtask

    task automatic test_reset_midline;
        logic [26:0] e;
        MODE = 2'd0;
        DUTY = {8'd25, 8'd88};
        wait_frame;
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({HD, VD, DEN, GREST, NCLK, FRAME_START, R, G, B} !== {6'b110000, 24'h0})
            $display("FAIL midline_reset: got %h need %h", {HD, VD, DEN, GREST, NCLK, FRAME_START, R, G, B}, {6'b110000, 24'h0});
        else passes++;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({GREST, FRAME_START} !== 2'b10) $display("FAIL midline_release: got %b need 10", {GREST, FRAME_START});
        else passes++;
        @(negedge CLK);
        for (int n = 0; n < FT; n++) begin
            if (n > 0) repeat (2) @(negedge CLK);
            e = model(n, 2, 0, 88, 25, 0);
            checks++;
            if ({FRAME_START, HD, VD, DEN, R, G, B} !== {n == 0, e})
                $display("FAIL restart n=%0d: got %h need %h", n, {FRAME_START, HD, VD, DEN, R, G, B}, {n == 0, e});
            else passes++;
        end
    endtask

    initial begin
        test_reset;
        test_timing;
        test_bars;
        test_clamp_midframe;
        test_colour_modes;
        test_num_ch3;
        test_random;
        test_reset_midline;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
